hnd_receiver: RTL and testbench
===============================

HND_RECEIVER -- requirements
Module: hnd_receiver

Interface
REQ-001 SHALL have parameter PID_READY, default 3'b001, handshake pid meaning "sender ready".
REQ-002 SHALL have parameter PID_ACK, default 3'b010, handshake pid meaning "acknowledge".
REQ-003 SHALL have parameter PID_LOST, default 3'b100, handshake pid meaning "sender game lost".
REQ-004 SHALL have parameter CNT_W, default 4, width of the error and ACK counters.
REQ-005 SHALL have port clk, input, 1, the only clock; every flop is rising-edge.
REQ-006 SHALL have port rst, input, 1, reset; synchronous and active-high.
REQ-007 SHALL have port serial_in_h, input, 1, handshake lane, sampled every clk.
REQ-008 SHALL have port game_active, input, 1, local game in progress.
REQ-009 SHALL have port ack_received, output, 1, one-cycle pulse on a valid ACK frame.
REQ-010 SHALL have port ack_seqNum, output, 1, seqNum of the most recent valid ACK.
REQ-011 SHALL have port send_ready_ACK, output, 1, one-cycle pulse requesting that the local sender transmit an ACK.
REQ-012 SHALL have port rx_seqNum, output, 1, seqNum to echo in the requested ACK.
REQ-013 SHALL have port opponent_ready, output, 1, level, opponent has declared ready.
REQ-014 SHALL have port opponent_lost, output, 1, level, opponent has topped out.
REQ-015 SHALL have port hnd_error_cnt, output, CNT_W, count of rejected frames.
REQ-016 SHALL have port acks_received_cnt, output, CNT_W, count of valid ACK frames.

Function
REQ-017 The frame format SHALL be 9 bits, MSB first: start bit 1, pid[2:0], pid_n[2:0], seqNum, seqNum_n. The idle line is 0.
REQ-018 The FSM SHALL have three states. IDLE goes to RECV when serial_in_h=1. RECV shifts 8 payload bits, one per clk, then goes to CHECK. CHECK goes to RECV if serial_in_h=1 in that cycle, otherwise to IDLE.
REQ-019 A frame is valid only if pid_n==~pid, seqNum_n==~seqNum, and pid is one of the three PID parameters. Any other frame is rejected.
REQ-020 On a rejected frame, in CHECK: hnd_error_cnt increments, saturating at all-ones; no other output changes; no send_ready_ACK.
REQ-021 All output pulses SHALL be asserted in the CHECK cycle, i.e. exactly 1 clk after the last payload bit is sampled.
REQ-022 Valid ACK: ack_received=1 for one cycle; ack_seqNum takes seqNum; acks_received_cnt increments, wrapping; no send_ready_ACK.
REQ-023 Valid READY or LOST: send_ready_ACK=1 for one cycle; rx_seqNum takes seqNum. This applies even to duplicates.
REQ-024 Duplicate rule: a READY or LOST whose seqNum equals last_seq, the register holding the seqNum of the last accepted READY/LOST, SHALL be ACKed only; it SHALL NOT change opponent_ready or opponent_lost. last_seq updates on every non-duplicate READY/LOST.
REQ-025 A non-duplicate READY with game_active=0 SHALL set opponent_ready and clear opponent_lost. A READY with game_active=1 is ACKed and otherwise ignored.
REQ-026 A non-duplicate LOST with game_active=1 SHALL set opponent_lost. A LOST with game_active=0 is ACKed and otherwise ignored.
REQ-027 opponent_ready SHALL clear in any cycle where game_active=1, unless that same cycle sets it. A set is impossible under REQ-025, so clear wins.
REQ-028 Back-to-back frames, with the start bit arriving in the CHECK cycle, SHALL be received with no lost bits.
REQ-029 serial_in_h SHALL be ignored while in RECV except as payload; a start bit cannot abort a frame in progress.

Reset
REQ-030 When rst=1 at a clk edge: state goes to IDLE, shift register and bit counter clear, all pulse and level outputs go to 0, both counters go to 0, last_seq goes to 1, ack_seqNum and rx_seqNum go to 0.
REQ-031 rst SHALL override every other event in the same cycle.
REQ-032 A frame in progress when rst is asserted SHALL be discarded with no outputs and no counter change.

Verification
REQ-033 Reset, game_active=0, send READY seq0 (1 001 110 0 1) -> send_ready_ACK pulse at the cycle after the last bit; rx_seqNum=0; opponent_ready=1.
REQ-034 Send the same READY seq0 again -> send_ready_ACK pulses; opponent_ready stays 1; last_seq stays 0. Then raise game_active -> opponent_ready=0 the next cycle.
REQ-035 game_active=1, send ACK seq1 (1 010 101 1 0) then, back-to-back, LOST seq1 (1 100 011 1 0) -> ack_received pulse with ack_seqNum=1 and acks_received_cnt=1; 9 cycles later send_ready_ACK pulses and opponent_lost=1.
REQ-036 Send a corrupted frame (1 001 111 0 1) 16 times -> no pulses; hnd_error_cnt saturates at 15.
REQ-037 Assert rst for one cycle after the 5th payload bit of a READY -> no outputs; FSM returns to IDLE; a following valid frame is decoded correctly.

Source files
------------

// File: rtl/hnd_receiver.sv
// hnd_receiver: serial handshake-lane frame receiver.
// Frames are 9 bits, MSB first: start(1), pid[2:0], pid_n[2:0], seqNum, seqNum_n.
// A frame is decoded on the clock edge that samples its last payload bit, so
// every pulse and status update is visible during the CHECK cycle that follows.
// All outputs come straight from flops.
module hnd_receiver #(
  parameter logic [2:0]  PID_READY = 3'b001,
  parameter logic [2:0]  PID_ACK   = 3'b010,
  parameter logic [2:0]  PID_LOST  = 3'b100,
  parameter int unsigned CNT_W     = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             serial_in_h,
  input  logic             game_active,
  output logic             ack_received,
  output logic             ack_seqNum,
  output logic             send_ready_ACK,
  output logic             rx_seqNum,
  output logic             opponent_ready,
  output logic             opponent_lost,
  output logic [CNT_W-1:0] hnd_error_cnt,
  output logic [CNT_W-1:0] acks_received_cnt
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RECV  = 2'd1,
    ST_CHECK = 2'd2
  } state_t;

  // True when both complement fields are exact inverses of their data fields.
  function automatic logic complement_ok(input logic [2:0] pid, input logic [2:0] pid_n,
                                         input logic seq, input logic seq_n);
    return (pid_n == ~pid) && (seq_n == ~seq);
  endfunction

  // True when the pid is one of the three handshake codes this lane carries.
  function automatic logic pid_known(input logic [2:0] pid);
    return (pid == PID_READY) || (pid == PID_ACK) || (pid == PID_LOST);
  endfunction

  // FSM and payload datapath
  state_t     state_r;
  state_t     state_nxt_s;
  logic [2:0] bit_cnt_r;
  logic [2:0] bit_cnt_nxt_s;
  logic [6:0] shift_r;
  logic [6:0] shift_nxt_s;

  // Frame decode
  logic       frame_done_s;
  logic [7:0] frame_s;
  logic [2:0] pid_s;
  logic [2:0] pid_n_s;
  logic       seq_s;
  logic       seq_n_s;
  logic       valid_s;

  // Output / status registers and their next values
  logic             ack_received_r;
  logic             ack_received_nxt_s;
  logic             ack_seq_r;
  logic             ack_seq_nxt_s;
  logic             send_ready_ack_r;
  logic             send_ready_ack_nxt_s;
  logic             rx_seq_r;
  logic             rx_seq_nxt_s;
  logic             opp_ready_r;
  logic             opp_ready_nxt_s;
  logic             opp_lost_r;
  logic             opp_lost_nxt_s;
  logic [CNT_W-1:0] err_cnt_r;
  logic [CNT_W-1:0] err_cnt_nxt_s;
  logic [CNT_W-1:0] ack_cnt_r;
  logic [CNT_W-1:0] ack_cnt_nxt_s;
  logic             last_seq_r;
  logic             last_seq_nxt_s;

  // State register: FSM state, payload bit counter and shift register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r   <= ST_IDLE;
      bit_cnt_r <= 3'd0;
      shift_r   <= 7'd0;
    end else begin
      state_r   <= state_nxt_s;
      bit_cnt_r <= bit_cnt_nxt_s;
      shift_r   <= shift_nxt_s;
    end
  end

  // Next-state logic: start bit detection, payload shifting, CHECK turnaround.
  always_comb begin
    state_nxt_s   = state_r;
    bit_cnt_nxt_s = bit_cnt_r;
    shift_nxt_s   = shift_r;
    case (state_r)
      ST_IDLE: begin
        if (serial_in_h) begin
          state_nxt_s   = ST_RECV;
          bit_cnt_nxt_s = 3'd0;
        end else begin
          state_nxt_s   = ST_IDLE;
        end
      end
      ST_RECV: begin
        // Every RECV cycle consumes one payload bit; a 1 here is never a start bit.
        shift_nxt_s = {shift_r[5:0], serial_in_h};
        if (bit_cnt_r == 3'd7) begin
          state_nxt_s   = ST_CHECK;
          bit_cnt_nxt_s = 3'd0;
        end else begin
          state_nxt_s   = ST_RECV;
          bit_cnt_nxt_s = bit_cnt_r + 3'd1;
        end
      end
      ST_CHECK: begin
        // A start bit here begins a back-to-back frame without losing a bit.
        if (serial_in_h) begin
          state_nxt_s   = ST_RECV;
          bit_cnt_nxt_s = 3'd0;
        end else begin
          state_nxt_s   = ST_IDLE;
        end
      end
      default: begin
        state_nxt_s   = ST_IDLE;
        bit_cnt_nxt_s = 3'd0;
        shift_nxt_s   = 7'd0;
      end
    endcase
  end

  // Output logic: decode the completed frame and compute next output/status values.
  always_comb begin
    frame_done_s = (state_r == ST_RECV) && (bit_cnt_r == 3'd7);
    frame_s      = {shift_r, serial_in_h};
    pid_s        = frame_s[7:5];
    pid_n_s      = frame_s[4:2];
    seq_s        = frame_s[1];
    seq_n_s      = frame_s[0];
    valid_s      = complement_ok(pid_s, pid_n_s, seq_s, seq_n_s) && pid_known(pid_s);

    ack_received_nxt_s   = 1'b0;
    send_ready_ack_nxt_s = 1'b0;
    ack_seq_nxt_s        = ack_seq_r;
    rx_seq_nxt_s         = rx_seq_r;
    opp_ready_nxt_s      = opp_ready_r;
    opp_lost_nxt_s       = opp_lost_r;
    err_cnt_nxt_s        = err_cnt_r;
    ack_cnt_nxt_s        = ack_cnt_r;
    last_seq_nxt_s       = last_seq_r;

    if (frame_done_s) begin
      if (!valid_s) begin
        // Rejected frame: only the saturating error counter moves.
        if (err_cnt_r != {CNT_W{1'b1}}) begin
          err_cnt_nxt_s = err_cnt_r + CNT_W'(1);
        end else begin
          err_cnt_nxt_s = err_cnt_r;
        end
      end else if (pid_s == PID_ACK) begin
        ack_received_nxt_s = 1'b1;
        ack_seq_nxt_s      = seq_s;
        ack_cnt_nxt_s      = ack_cnt_r + CNT_W'(1);
      end else begin
        // READY or LOST: always acknowledged, duplicates included.
        send_ready_ack_nxt_s = 1'b1;
        rx_seq_nxt_s         = seq_s;
        if (seq_s != last_seq_r) begin
          last_seq_nxt_s = seq_s;
          if ((pid_s == PID_READY) && !game_active) begin
            opp_ready_nxt_s = 1'b1;
            opp_lost_nxt_s  = 1'b0;
          end else if ((pid_s == PID_LOST) && game_active) begin
            opp_lost_nxt_s  = 1'b1;
          end else begin
            opp_ready_nxt_s = opp_ready_r;
            opp_lost_nxt_s  = opp_lost_r;
          end
        end else begin
          last_seq_nxt_s = last_seq_r;
        end
      end
    end else begin
      err_cnt_nxt_s = err_cnt_r;
    end

    // A running game always drops the ready flag; a READY cannot set it then.
    if (game_active) begin
      opp_ready_nxt_s = 1'b0;
    end else begin
      opp_ready_nxt_s = opp_ready_nxt_s;
    end
  end

  // Output register: pulses, captured sequence numbers, status levels, counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      ack_received_r   <= 1'b0;
      ack_seq_r        <= 1'b0;
      send_ready_ack_r <= 1'b0;
      rx_seq_r         <= 1'b0;
      opp_ready_r      <= 1'b0;
      opp_lost_r       <= 1'b0;
      err_cnt_r        <= {CNT_W{1'b0}};
      ack_cnt_r        <= {CNT_W{1'b0}};
      last_seq_r       <= 1'b1;
    end else begin
      ack_received_r   <= ack_received_nxt_s;
      ack_seq_r        <= ack_seq_nxt_s;
      send_ready_ack_r <= send_ready_ack_nxt_s;
      rx_seq_r         <= rx_seq_nxt_s;
      opp_ready_r      <= opp_ready_nxt_s;
      opp_lost_r       <= opp_lost_nxt_s;
      err_cnt_r        <= err_cnt_nxt_s;
      ack_cnt_r        <= ack_cnt_nxt_s;
      last_seq_r       <= last_seq_nxt_s;
    end
  end

  assign ack_received      = ack_received_r;
  assign ack_seqNum        = ack_seq_r;
  assign send_ready_ACK    = send_ready_ack_r;
  assign rx_seqNum         = rx_seq_r;
  assign opponent_ready    = opp_ready_r;
  assign opponent_lost     = opp_lost_r;
  assign hnd_error_cnt     = err_cnt_r;
  assign acks_received_cnt = ack_cnt_r;

endmodule

// File: tb/tb_hnd_receiver.sv
// Self-checking bench for hnd_receiver: directed handshake scenarios followed by
// randomized frames, gaps, game_active changes and mid-frame resets, all compared
// every cycle against a frame-level behavioural model.
module tb_hnd_receiver;

  logic       clk;
  logic       rst;
  logic       serial_in_h;
  logic       game_active;
  logic       ack_received;
  logic       ack_seqNum;
  logic       send_ready_ACK;
  logic       rx_seqNum;
  logic       opponent_ready;
  logic       opponent_lost;
  logic [3:0] hnd_error_cnt;
  logic [3:0] acks_received_cnt;

  int n_checks;
  int n_errors;

  // Reference model state
  logic m_ack_rx, m_send, m_ack_seq, m_rx_seq, m_ready, m_lost, m_last;
  int   m_err, m_acks;

  hnd_receiver dut (
    .clk               (clk),
    .rst               (rst),
    .serial_in_h       (serial_in_h),
    .game_active       (game_active),
    .ack_received      (ack_received),
    .ack_seqNum        (ack_seqNum),
    .send_ready_ACK    (send_ready_ACK),
    .rx_seqNum         (rx_seqNum),
    .opponent_ready    (opponent_ready),
    .opponent_lost     (opponent_lost),
    .hnd_error_cnt     (hnd_error_cnt),
    .acks_received_cnt (acks_received_cnt)
  );

  // Free-running clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_ack_rx = 1'b0; m_send = 1'b0; m_ack_seq = 1'b0; m_rx_seq = 1'b0;
    m_ready = 1'b0; m_lost = 1'b0; m_last = 1'b1; m_err = 0; m_acks = 0;
  endtask

  // Apply the handshake rules to one complete 9-bit frame.
  task automatic model_frame(input logic [8:0] f);
    logic [2:0] pid, pidn;
    logic       s, sn;
    bit         ok;
    pid = f[7:5]; pidn = f[4:2]; s = f[1]; sn = f[0];
    ok = (pidn == ~pid) && (sn != s) && (pid == 3'b001 || pid == 3'b010 || pid == 3'b100);
    if (!ok) begin
      if (m_err < 15) m_err = m_err + 1;
    end else if (pid == 3'b010) begin
      m_ack_rx = 1'b1; m_ack_seq = s; m_acks = (m_acks + 1) % 16;
    end else begin
      m_send = 1'b1; m_rx_seq = s;
      if (s != m_last) begin
        m_last = s;
        if (pid == 3'b001 && !game_active) begin m_ready = 1'b1; m_lost = 1'b0; end
        if (pid == 3'b100 && game_active) m_lost = 1'b1;
      end
    end
  endtask

  task automatic compare_all();
    check_val("ack_received", 32'(ack_received), 32'(m_ack_rx));
    check_val("ack_seqNum", 32'(ack_seqNum), 32'(m_ack_seq));
    check_val("send_ready_ACK", 32'(send_ready_ACK), 32'(m_send));
    check_val("rx_seqNum", 32'(rx_seqNum), 32'(m_rx_seq));
    check_val("opponent_ready", 32'(opponent_ready), 32'(m_ready));
    check_val("opponent_lost", 32'(opponent_lost), 32'(m_lost));
    check_val("hnd_error_cnt", 32'(hnd_error_cnt), 32'(m_err));
    check_val("acks_received_cnt", 32'(acks_received_cnt), 32'(m_acks));
  endtask

  // One clock: drive line and reset, advance, update model, compare everything.
  task automatic step(input logic b, input logic rst_v, input logic done, input logic [8:0] frm);
    serial_in_h = b;
    rst = rst_v;
    @(posedge clk);
    #1;
    m_ack_rx = 1'b0;
    m_send = 1'b0;
    if (rst_v) begin
      model_reset();
    end else begin
      if (done) model_frame(frm);
      if (game_active) m_ready = 1'b0;
    end
    compare_all();
  endtask

  task automatic send_frame(input logic [8:0] frm);
    for (int i = 8; i >= 0; i--) step(frm[i], 1'b0, (i == 0), frm);
  endtask

  // Start bit plus n payload bits, then reset in place of payload bit n+1.
  task automatic send_partial(input logic [8:0] frm, input int n);
    for (int i = 8; i >= 8 - n; i--) step(frm[i], 1'b0, 1'b0, frm);
    step(frm[7 - n], 1'b1, 1'b0, frm);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 9'd0);
  endtask

  localparam logic [8:0] F_READY0 = 9'b1_001_110_0_1;
  localparam logic [8:0] F_READY1 = 9'b1_001_110_1_0;
  localparam logic [8:0] F_ACK1   = 9'b1_010_101_1_0;
  localparam logic [8:0] F_LOST1  = 9'b1_100_011_1_0;
  localparam logic [8:0] F_BAD    = 9'b1_001_111_0_1;

  initial begin
    logic [2:0] pid;
    logic       s;
    logic [8:0] frm;
    logic [7:0] rnd;
    n_checks = 0;
    n_errors = 0;
    serial_in_h = 1'b0;
    game_active = 1'b0;
    rst = 1'b1;
    model_reset();

    // Reset state
    step(1'b0, 1'b1, 1'b0, 9'd0);
    step(1'b1, 1'b1, 1'b0, 9'd0);
    idle(2);

    // READY seq0 while not in a game: ACK requested, opponent ready
    send_frame(F_READY0);
    idle(1);
    // Duplicate READY seq0: ACKed only
    send_frame(F_READY0);
    idle(1);
    game_active = 1'b1;
    idle(2);

    // ACK seq1 then back-to-back LOST seq1 during a game
    send_frame(F_ACK1);
    send_frame(F_LOST1);
    idle(2);

    // Sixteen corrupted frames saturate the error counter
    for (int i = 0; i < 16; i++) send_frame(F_BAD);
    idle(1);

    // Reset after the 5th payload bit of a READY, then a clean frame
    game_active = 1'b0;
    send_partial(F_READY0, 5);
    idle(2);
    // last_seq is 1 after reset: READY seq1 is a duplicate, READY seq0 is not
    send_frame(F_READY1);
    send_frame(F_READY0);
    idle(1);

    // Randomized traffic
    for (int n = 0; n < 300; n++) begin
      if ($urandom_range(0, 3) == 0) game_active = 1'($urandom_range(0, 1));
      idle($urandom_range(0, 2));
      if ($urandom_range(0, 3) == 0) game_active = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 9) < 6) begin
        case ($urandom_range(0, 2))
          0: pid = 3'b001;
          1: pid = 3'b010;
          default: pid = 3'b100;
        endcase
        s = 1'($urandom_range(0, 1));
        frm = {1'b1, pid, ~pid, s, ~s};
      end else begin
        rnd = 8'($urandom);
        frm = {1'b1, rnd};
      end
      if ($urandom_range(0, 24) == 0) send_partial(frm, $urandom_range(0, 7));
      else send_frame(frm);
    end
    idle(3);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
